// File: rtl/fu_share_arbiter.sv
// fu_share_arbiter
// ----------------
// Shares one multi-cycle functional unit (branch / address adder) among
// NUM_REQ reservation stations. A round-robin pick selects one issuing RS.
// The block then pulses fu_start, waits for fu_done, and parks the result in
// a CDB slot until the CDB arbiter acks it. In the ack cycle it returns a
// one-cycle resp to the winning RS.
//
// Ports
//   clk        system clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   flush      synchronous pipeline flush; drops any in-flight op
//   req        per-RS issue request, held until resp or flush
//   req_tag    per-RS destination ROB tag, stable while req is high
//   resp       one-hot completion pulse to the granted RS (ack cycle only)
//   fu_start   one-cycle pulse telling the FU to latch the operands at fu_sel
//   fu_sel     index of the granted RS (operand mux select), 0 when idle
//   fu_abort   one-cycle pulse telling the FU to drop its in-flight op
//   fu_done    FU result valid pulse
//   fu_result  FU result data
//   cdb_valid  CDB slot valid
//   cdb_tag    CDB slot ROB tag
//   cdb_data   CDB slot data
//   cdb_ack    CDB arbiter accepted the slot this cycle
module fu_share_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int ROB_DEPTH = 4,
    localparam int SW = $clog2(NUM_REQ),
    localparam int TW = $clog2(ROB_DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0][TW-1:0] req_tag,
    output logic [NUM_REQ-1:0]         resp,
    output logic                       fu_start,
    output logic [SW-1:0]              fu_sel,
    output logic                       fu_abort,
    input  logic                       fu_done,
    input  logic [31:0]                fu_result,
    output logic                       cdb_valid,
    output logic [TW-1:0]              cdb_tag,
    output logic [31:0]                cdb_data,
    input  logic                       cdb_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t        state;
    logic [SW-1:0] rr_ptr;
    logic [SW-1:0] grant_idx;
    logic [TW-1:0] tag_q;
    logic [31:0]   result_q;

    logic [SW-1:0] winner;
    logic [SW-1:0] cand;
    logic          any_req;

    // Round-robin scan starting at rr_ptr. The candidate index wraps by
    // compare rather than by modulo so NUM_REQ need not be a power of two.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        cand    = rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!any_req && req[cand]) begin
                winner  = cand;
                any_req = 1'b1;
            end
            cand = (cand == SW'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
        end
    end

    // Main sequencer. fu_start is registered so it is high exactly in the
    // first BUSY cycle; a fu_done seen while fu_start is high is a protocol
    // violation and is ignored. Flush overrides everything and leaves
    // rr_ptr untouched, so an aborted op does not cost its RS its turn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_idx <= '0;
            tag_q     <= '0;
            result_q  <= '0;
            fu_start  <= 1'b0;
            cdb_valid <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            fu_start  <= 1'b0;
            cdb_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_idx <= winner;
                        tag_q     <= req_tag[winner];
                        fu_start  <= 1'b1;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    fu_start <= 1'b0;
                    if (fu_done && !fu_start) begin
                        result_q  <= fu_result;
                        cdb_valid <= 1'b1;
                        state     <= WB;
                    end
                end
                WB: begin
                    if (cdb_ack) begin
                        rr_ptr    <= (grant_idx == SW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                        cdb_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    fu_start  <= 1'b0;
                    cdb_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // tag_q and result_q only change on grant and on done, so the slot
    // contents are naturally stable for the whole WB stay.
    assign cdb_tag  = cdb_valid ? tag_q : '0;
    assign cdb_data = cdb_valid ? result_q : '0;
    assign fu_sel   = (state != IDLE) ? grant_idx : '0;
    assign fu_abort = flush && (state != IDLE);

    // Completion pulse goes out in the ack cycle unless a flush discards it.
    always_comb begin
        resp = '0;
        if (state == WB && cdb_ack && !flush) begin
            resp[grant_idx] = 1'b1;
        end
    end

endmodule

// File: tb/tb_fu_share_arbiter.sv
// tb_fu_share_arbiter
// -------------------
// Directed bench for fu_share_arbiter with NUM_REQ=2, ROB_DEPTH=4.
// A behavioural model of the sharing protocol is updated on each rising edge
// and compared against every DUT output on each falling edge; the directed
// scenarios additionally pin hand-computed literal values.
module tb_fu_share_arbiter;

    localparam int N = 2;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic [1:0]       req;
    logic [1:0][1:0]  req_tag;
    logic [1:0]       resp;
    logic             fu_start;
    logic [0:0]       fu_sel;
    logic             fu_abort;
    logic             fu_done;
    logic [31:0]      fu_result;
    logic             cdb_valid;
    logic [1:0]       cdb_tag;
    logic [31:0]      cdb_data;
    logic             cdb_ack;

    int n_cmp  = 0;
    int n_fail = 0;

    fu_share_arbiter #(.NUM_REQ(2), .ROB_DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .req       (req),
        .req_tag   (req_tag),
        .resp      (resp),
        .fu_start  (fu_start),
        .fu_sel    (fu_sel),
        .fu_abort  (fu_abort),
        .fu_done   (fu_done),
        .fu_result (fu_result),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .cdb_ack   (cdb_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp = n_cmp + 1;
        if (actual !== expected) begin
            n_fail = n_fail + 1;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: an op is either absent (phase 0), being computed
    // (phase 1, age counts cycles since start) or waiting on the CDB (phase 2).
    int          m_phase;
    int          m_age;
    int          m_rr;
    int          m_g;
    logic [1:0]  m_tag;
    logic [31:0] m_data;

    function automatic int pick(input logic [1:0] r, input int ptr);
        int w;
        w = -1;
        for (int k = 0; k < N; k++) begin
            if (w < 0 && r[(ptr + k) % N]) w = (ptr + k) % N;
        end
        return w;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_age   <= 0;
            m_rr    <= 0;
            m_g     <= 0;
            m_tag   <= '0;
            m_data  <= '0;
        end else if (flush) begin
            m_phase <= 0;
        end else if (m_phase == 0) begin
            if (req != 2'b00) begin
                m_g     <= pick(req, m_rr);
                m_tag   <= req_tag[pick(req, m_rr)];
                m_phase <= 1;
                m_age   <= 0;
            end
        end else if (m_phase == 1) begin
            m_age <= m_age + 1;
            if (m_age > 0 && fu_done) begin
                m_data  <= fu_result;
                m_phase <= 2;
            end
        end else begin
            if (cdb_ack) begin
                m_rr    <= (m_g + 1) % N;
                m_phase <= 0;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            check_output("m_fu_start",  {31'd0, fu_start},  {31'd0, (m_phase == 1 && m_age == 0)});
            check_output("m_fu_sel",    {31'd0, fu_sel},    (m_phase != 0) ? m_g : 0);
            check_output("m_fu_abort",  {31'd0, fu_abort},  {31'd0, (flush && m_phase != 0)});
            check_output("m_cdb_valid", {31'd0, cdb_valid}, {31'd0, (m_phase == 2)});
            check_output("m_cdb_tag",   {30'd0, cdb_tag},   (m_phase == 2) ? {30'd0, m_tag} : 32'd0);
            check_output("m_cdb_data",  cdb_data,           (m_phase == 2) ? m_data : 32'd0);
            check_output("m_resp",      {30'd0, resp},
                         (m_phase == 2 && cdb_ack && !flush) ? (32'd1 << m_g) : 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one op from an IDLE cycle with req already driven: start, wait
    // lat cycles, done, then hold the slot ack_wait cycles before acking.
    task automatic apply_stimulus(input int exp_idx, input int lat, input int ack_wait,
                                  input logic [31:0] data, input logic [1:0] exp_tag, input bit drop);
        tick();
        check_output("op_fu_start", {31'd0, fu_start}, 32'd1);
        check_output("op_fu_sel", {31'd0, fu_sel}, exp_idx);
        repeat (lat) tick();
        fu_done   = 1'b1;
        fu_result = data;
        tick();
        fu_done   = 1'b0;
        fu_result = 32'h0;
        check_output("op_cdb_valid", {31'd0, cdb_valid}, 32'd1);
        check_output("op_cdb_tag", {30'd0, cdb_tag}, {30'd0, exp_tag});
        check_output("op_cdb_data", cdb_data, data);
        for (int w = 0; w < ack_wait; w++) begin
            tick();
            check_output("bp_cdb_valid", {31'd0, cdb_valid}, 32'd1);
            check_output("bp_cdb_tag", {30'd0, cdb_tag}, {30'd0, exp_tag});
            check_output("bp_cdb_data", cdb_data, data);
            check_output("bp_resp", {30'd0, resp}, 32'd0);
        end
        cdb_ack = 1'b1;
        #1;
        check_output("op_resp", {30'd0, resp}, 32'd1 << exp_idx);
        tick();
        cdb_ack = 1'b0;
        if (drop) req[exp_idx] = 1'b0;
        check_output("bubble_cdb_valid", {31'd0, cdb_valid}, 32'd0);
        check_output("bubble_fu_start", {31'd0, fu_start}, 32'd0);
        check_output("bubble_fu_sel", {31'd0, fu_sel}, 32'd0);
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        req       = 2'b00;
        req_tag   = '0;
        fu_done   = 1'b0;
        fu_result = 32'h0;
        cdb_ack   = 1'b0;
        #12;
        check_output("rst_resp", {30'd0, resp}, 32'd0);
        check_output("rst_fu_start", {31'd0, fu_start}, 32'd0);
        check_output("rst_cdb_valid", {31'd0, cdb_valid}, 32'd0);
        check_output("rst_cdb_data", cdb_data, 32'd0);
        check_output("rst_fu_sel", {31'd0, fu_sel}, 32'd0);
        rst_n = 1'b1;
        tick();

        $display("[TB] single op");
        req        = 2'b01;
        req_tag[0] = 2'd2;
        apply_stimulus(0, 2, 1, 32'hCAFE_0001, 2'd2, 1'b1);

        $display("[TB] round robin");
        do_reset();
        req        = 2'b11;
        req_tag[0] = 2'd1;
        req_tag[1] = 2'd3;
        apply_stimulus(0, 1, 0, 32'h1111_0000, 2'd1, 1'b0);
        apply_stimulus(1, 2, 0, 32'h2222_0000, 2'd3, 1'b0);
        apply_stimulus(0, 1, 1, 32'h3333_0000, 2'd1, 1'b0);
        apply_stimulus(1, 3, 0, 32'h4444_0000, 2'd3, 1'b0);
        req = 2'b00;

        $display("[TB] cdb backpressure");
        req        = 2'b01;
        req_tag[0] = 2'd2;
        apply_stimulus(0, 3, 5, 32'hDEAD_BEEF, 2'd2, 1'b1);

        $display("[TB] flush in busy");
        req        = 2'b11;
        req_tag[0] = 2'd0;
        req_tag[1] = 2'd1;
        tick();
        check_output("fl_fu_start", {31'd0, fu_start}, 32'd1);
        check_output("fl_fu_sel", {31'd0, fu_sel}, 32'd1);
        tick();
        flush     = 1'b1;
        fu_done   = 1'b1;
        fu_result = 32'h5555_AAAA;
        #1;
        check_output("fl_fu_abort", {31'd0, fu_abort}, 32'd1);
        check_output("fl_resp", {30'd0, resp}, 32'd0);
        tick();
        flush   = 1'b0;
        fu_done = 1'b0;
        check_output("fl_idle_cdb_valid", {31'd0, cdb_valid}, 32'd0);
        check_output("fl_idle_fu_sel", {31'd0, fu_sel}, 32'd0);
        check_output("fl_idle_fu_abort", {31'd0, fu_abort}, 32'd0);
        apply_stimulus(1, 1, 0, 32'h0F0F_0F0F, 2'd1, 1'b1);
        req = 2'b00;

        $display("[TB] async reset in writeback");
        req        = 2'b10;
        req_tag[1] = 2'd3;
        tick();
        check_output("ar_fu_sel", {31'd0, fu_sel}, 32'd1);
        tick();
        fu_done   = 1'b1;
        fu_result = 32'h7777_7777;
        tick();
        fu_done = 1'b0;
        cdb_ack = 1'b1;
        #1;
        check_output("ar_resp_before", {30'd0, resp}, 32'd2);
        rst_n = 1'b0;
        #1;
        check_output("ar_cdb_valid", {31'd0, cdb_valid}, 32'd0);
        check_output("ar_resp", {30'd0, resp}, 32'd0);
        check_output("ar_fu_start", {31'd0, fu_start}, 32'd0);
        check_output("ar_fu_abort", {31'd0, fu_abort}, 32'd0);
        cdb_ack = 1'b0;
        rst_n   = 1'b1;
        req        = 2'b11;
        req_tag[0] = 2'd2;
        apply_stimulus(0, 1, 0, 32'h8888_0001, 2'd2, 1'b1);

        $display("[TB] early done");
        tick();
        check_output("ed_fu_start", {31'd0, fu_start}, 32'd1);
        check_output("ed_fu_sel", {31'd0, fu_sel}, 32'd1);
        fu_done   = 1'b1;
        fu_result = 32'h0000_0BAD;
        tick();
        fu_done = 1'b0;
        check_output("ed_still_busy_valid", {31'd0, cdb_valid}, 32'd0);
        check_output("ed_still_busy_sel", {31'd0, fu_sel}, 32'd1);
        tick();
        fu_done   = 1'b1;
        fu_result = 32'h0000_600D;
        tick();
        fu_done = 1'b0;
        check_output("ed_cdb_valid", {31'd0, cdb_valid}, 32'd1);
        check_output("ed_cdb_data", cdb_data, 32'h0000_600D);
        check_output("ed_cdb_tag", {30'd0, cdb_tag}, 32'd3);
        cdb_ack = 1'b1;
        #1;
        check_output("ed_resp", {30'd0, resp}, 32'd2);
        tick();
        cdb_ack = 1'b0;
        req     = 2'b00;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
